// File: rtl/pipeline_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding, counter operations and output presets for pipeline_ctrl
package pipe_ctrl_pkg;
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    DIV_WAIT = 3'd1,
    MEM_WAIT = 3'd2,
    ERROR    = 3'd3,
    HALTED   = 3'd4
  } ctrl_state_e;
  typedef enum logic [2:0] {CNT_HOLD, CNT_LOAD, CNT_INC, CNT_DEC, CNT_CLR} cnt_op_e;
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_hold;
    logic exm_hold;
    logic flush_ifid;
    logic flush_idex;
    logic flush_ex;
  } ctrl_out_t;
  localparam ctrl_out_t ADVANCE_OUT  = 7'b1100000;
  localparam ctrl_out_t RESET_OUT    = 7'b0000111;
  localparam ctrl_out_t HALT_OUT     = 7'b0000110;
  localparam ctrl_out_t ERROR_OUT    = 7'b0011110;
  localparam ctrl_out_t MEM_STALL    = 7'b0011000;
  localparam ctrl_out_t DIV_STALL    = 7'b0010001;
  localparam ctrl_out_t BRANCH_OUT   = 7'b1100110;
  localparam ctrl_out_t LOAD_USE_OUT = 7'b0000010;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and buffer-control outputs between the core and pipeline_ctrl
interface pipeline_ctrl_if;
  logic       IDEX_MemRead;
  logic [3:0] IDEX_RegRD;
  logic [3:0] IFID_RegRS;
  logic [3:0] IFID_RegRT;
  logic       IFID_UsesRS;
  logic       IFID_UsesRT;
  logic       Branch_Taken;
  logic       Div_Start;
  logic       Mem_Req;
  logic       Mem_Ready;
  logic       Halt;
  logic       PC_Write;
  logic       IFID_Write;
  logic       IDEX_Hold;
  logic       EXM_Hold;
  logic       FLUSH_IFID;
  logic       FLUSH_IDEX;
  logic       FLUSH_EX;
  logic       Div_Done;
  logic       Mem_Err;
  logic [2:0] Ctrl_State;
  modport master (
    output IDEX_MemRead, IDEX_RegRD, IFID_RegRS, IFID_RegRT, IFID_UsesRS, IFID_UsesRT,
           Branch_Taken, Div_Start, Mem_Req, Mem_Ready, Halt,
    input  PC_Write, IFID_Write, IDEX_Hold, EXM_Hold, FLUSH_IFID, FLUSH_IDEX, FLUSH_EX,
           Div_Done, Mem_Err, Ctrl_State
  );
  modport slave (
    input  IDEX_MemRead, IDEX_RegRD, IFID_RegRS, IFID_RegRT, IFID_UsesRS, IFID_UsesRT,
           Branch_Taken, Div_Start, Mem_Req, Mem_Ready, Halt,
    output PC_Write, IFID_Write, IDEX_Hold, EXM_Hold, FLUSH_IFID, FLUSH_IDEX, FLUSH_EX,
           Div_Done, Mem_Err, Ctrl_State
  );
endinterface

// File: rtl/pipeline_ctrl_counter.sv
// ctrl_cycle_counter: shared load/increment/decrement/clear counter with zero flag
module ctrl_cycle_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cnt_op_e          i_op,
  input  logic [CNT_W-1:0] i_load,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= i_op == CNT_LOAD ? i_load :
                  i_op == CNT_INC  ? r_cnt + CNT_W'(1) :
                  i_op == CNT_DEC  ? r_cnt - CNT_W'(1) :
                  i_op == CNT_CLR  ? '0 : r_cnt;
  assign o_cnt  = r_cnt;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: advance/hold/flush sequencing for the four-stage core's pipeline buffers
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES  = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            rst_n,
  pipeline_ctrl_if.slave bus
);
  ctrl_state_e      r_state, w_next;
  cnt_op_e          w_op;
  ctrl_out_t        w_out;
  logic [CNT_W-1:0] w_cnt;
  logic             w_zero, r_div_done, r_mem_err;
  logic             w_load_use, w_mem_stall, w_div_pass, w_timeout;
  ctrl_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_op   (w_op),
    .i_load (CNT_W'(DIV_CYCLES - 1)),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );
  assign w_load_use  = bus.IDEX_MemRead &
                       ((bus.IFID_UsesRS & (bus.IFID_RegRS == bus.IDEX_RegRD)) |
                        (bus.IFID_UsesRT & (bus.IFID_RegRT == bus.IDEX_RegRD)));
  assign w_mem_stall = bus.Mem_Req & ~bus.Mem_Ready;
  // The Div_Start cycle is the first stall, so the result passes while the count steps 1 -> 0
  assign w_div_pass  = w_zero | (w_cnt == CNT_W'(1));
  assign w_timeout   = w_cnt == CNT_W'(MEM_TIMEOUT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= RUN;
      r_div_done <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_div_done <= (r_state == DIV_WAIT) & w_div_pass;
      r_mem_err  <= r_mem_err | (w_next == ERROR);
    end
  always_comb begin
    w_next = r_state;
    w_op   = CNT_HOLD;
    case (r_state)
      RUN:
        if (bus.Halt) w_next = HALTED;
        else if (w_mem_stall) begin
          w_next = MEM_WAIT;
          w_op   = CNT_CLR;
        end else if (bus.Div_Start) begin
          w_next = DIV_WAIT;
          w_op   = CNT_LOAD;
        end
      DIV_WAIT: begin
        w_next = w_div_pass ? RUN : DIV_WAIT;
        w_op   = w_div_pass ? CNT_CLR : CNT_DEC;
      end
      MEM_WAIT: begin
        w_next = bus.Mem_Ready ? RUN : w_timeout ? ERROR : MEM_WAIT;
        w_op   = bus.Mem_Ready ? CNT_HOLD : CNT_INC;
      end
      default: w_next = r_state;
    endcase
  end
  always_comb begin
    w_out = ADVANCE_OUT;
    case (r_state)
      RUN:      w_out = bus.Halt         ? HALT_OUT :
                        w_mem_stall      ? MEM_STALL :
                        bus.Div_Start    ? DIV_STALL :
                        bus.Branch_Taken ? BRANCH_OUT :
                        w_load_use       ? LOAD_USE_OUT : ADVANCE_OUT;
      DIV_WAIT: w_out = w_div_pass ? ADVANCE_OUT : DIV_STALL;
      MEM_WAIT: w_out = bus.Mem_Ready ? ADVANCE_OUT : MEM_STALL;
      ERROR:    w_out = ERROR_OUT;
      HALTED:   w_out = HALT_OUT;
      default:  w_out = ADVANCE_OUT;
    endcase
    if (!rst_n) w_out = RESET_OUT;
  end
  assign bus.PC_Write   = w_out.pc_write;
  assign bus.IFID_Write = w_out.ifid_write;
  assign bus.IDEX_Hold  = w_out.idex_hold;
  assign bus.EXM_Hold   = w_out.exm_hold;
  assign bus.FLUSH_IFID = w_out.flush_ifid;
  assign bus.FLUSH_IDEX = w_out.flush_idex;
  assign bus.FLUSH_EX   = w_out.flush_ex;
  assign bus.Div_Done   = r_div_done;
  assign bus.Mem_Err    = r_mem_err;
  assign bus.Ctrl_State = r_state;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_pipeline_ctrl;
  typedef struct packed {
    logic       rn;
    logic       mr;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       div;
    logic       mreq;
    logic       mrdy;
    logic       halt;
  } in_t;
  typedef struct {
    string       nm;
    logic [11:0] v;
  } exp_t;
  // {PC_Write, IFID_Write, IDEX_Hold, EXM_Hold, FLUSH_IFID, FLUSH_IDEX, FLUSH_EX}
  localparam logic [6:0] ADV = 7'b1100000, RST = 7'b0000111, HLT = 7'b0000110, ERR = 7'b0011110;
  localparam logic [6:0] MEM = 7'b0011000, DIV = 7'b0010001, BR = 7'b1100110, LU = 7'b0000010;
  localparam logic [2:0] S_RUN = 3'd0, S_DIV = 3'd1, S_MEM = 3'd2, S_ERR = 3'd3, S_HLT = 3'd4;
  localparam in_t IDLE = '{rn: 1'b1, default: '0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  pipeline_ctrl_if bus ();
  pipeline_ctrl #(.DIV_CYCLES(16), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic cyc(input string nm, input in_t v, input logic [6:0] o, input logic dd,
                     input logic me, input logic [2:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = v.rn;
    bus.IDEX_MemRead = v.mr;
    bus.IDEX_RegRD   = v.rd;
    bus.IFID_RegRS   = v.rs;
    bus.IFID_RegRT   = v.rt;
    bus.IFID_UsesRS  = v.urs;
    bus.IFID_UsesRT  = v.urt;
    bus.Branch_Taken = v.br;
    bus.Div_Start    = v.div;
    bus.Mem_Req      = v.mreq;
    bus.Mem_Ready    = v.mrdy;
    bus.Halt         = v.halt;
    e.nm = nm;
    e.v  = {o, dd, me, st};
    q.push_back(e);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_t e;
        logic [11:0] act;
        e = q.pop_front();
        act = {bus.PC_Write, bus.IFID_Write, bus.IDEX_Hold, bus.EXM_Hold, bus.FLUSH_IFID,
               bus.FLUSH_IDEX, bus.FLUSH_EX, bus.Div_Done, bus.Mem_Err, bus.Ctrl_State};
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL %s: got ctl=%b dd=%b err=%b st=%0d, want ctl=%b dd=%b err=%b st=%0d",
                   e.nm, act[11:5], act[4], act[3], act[2:0], e.v[11:5], e.v[4], e.v[3], e.v[2:0]);
        end
      end
    end
  end
  initial begin
    bus.IDEX_MemRead = 1'b0;
    bus.IDEX_RegRD   = '0;
    bus.IFID_RegRS   = '0;
    bus.IFID_RegRT   = '0;
    bus.IFID_UsesRS  = 1'b0;
    bus.IFID_UsesRT  = 1'b0;
    bus.Branch_Taken = 1'b0;
    bus.Div_Start    = 1'b0;
    bus.Mem_Req      = 1'b0;
    bus.Mem_Ready    = 1'b0;
    bus.Halt         = 1'b0;
    cyc("reset_forced", '{rn: 1'b0, default: '0}, RST, 0, 0, S_RUN);
    cyc("idle_advance", IDLE, ADV, 0, 0, S_RUN);
    cyc("load_use_rs", '{rn: 1'b1, mr: 1'b1, rd: 4'd3, rs: 4'd3, urs: 1'b1, default: '0}, LU, 0, 0, S_RUN);
    cyc("load_use_one_bubble", IDLE, ADV, 0, 0, S_RUN);
    cyc("rs_unused_no_stall", '{rn: 1'b1, mr: 1'b1, rd: 4'd3, rs: 4'd3, default: '0}, ADV, 0, 0, S_RUN);
    cyc("load_use_rt", '{rn: 1'b1, mr: 1'b1, rd: 4'd3, rs: 4'd1, rt: 4'd3, urs: 1'b1, urt: 1'b1, default: '0}, LU, 0, 0, S_RUN);
    cyc("rd_mismatch", '{rn: 1'b1, mr: 1'b1, rd: 4'd4, rs: 4'd3, rt: 4'd5, urs: 1'b1, urt: 1'b1, default: '0}, ADV, 0, 0, S_RUN);
    cyc("branch_over_load_use", '{rn: 1'b1, mr: 1'b1, rd: 4'd3, rs: 4'd3, urs: 1'b1, br: 1'b1, default: '0}, BR, 0, 0, S_RUN);
    cyc("div_start", '{rn: 1'b1, div: 1'b1, default: '0}, DIV, 0, 0, S_RUN);
    for (int i = 0; i < 14; i++) cyc("div_wait", '{rn: 1'b1, div: 1'b1, default: '0}, DIV, 0, 0, S_DIV);
    cyc("div_pass", IDLE, ADV, 0, 0, S_DIV);
    cyc("div_done_pulse", IDLE, ADV, 1, 0, S_RUN);
    cyc("div_done_clears", IDLE, ADV, 0, 0, S_RUN);
    cyc("mem_not_ready_over_div", '{rn: 1'b1, mreq: 1'b1, div: 1'b1, default: '0}, MEM, 0, 0, S_RUN);
    cyc("mem_wait_1", '{rn: 1'b1, mreq: 1'b1, div: 1'b1, default: '0}, MEM, 0, 0, S_MEM);
    cyc("mem_wait_2", '{rn: 1'b1, mreq: 1'b1, div: 1'b1, default: '0}, MEM, 0, 0, S_MEM);
    cyc("mem_ready_release", '{rn: 1'b1, mreq: 1'b1, mrdy: 1'b1, div: 1'b1, default: '0}, ADV, 0, 0, S_MEM);
    cyc("deferred_div", '{rn: 1'b1, div: 1'b1, default: '0}, DIV, 0, 0, S_RUN);
    cyc("div_wait_before_reset", '{rn: 1'b1, div: 1'b1, default: '0}, DIV, 0, 0, S_DIV);
    cyc("reset_mid_div", '{rn: 1'b0, div: 1'b1, default: '0}, RST, 0, 0, S_RUN);
    cyc("after_div_abort", IDLE, ADV, 0, 0, S_RUN);
    cyc("timeout_enter", '{rn: 1'b1, mreq: 1'b1, default: '0}, MEM, 0, 0, S_RUN);
    for (int i = 0; i < 5; i++) cyc("timeout_wait", '{rn: 1'b1, mreq: 1'b1, default: '0}, MEM, 0, 0, S_MEM);
    cyc("error_entered", '{rn: 1'b1, mreq: 1'b1, default: '0}, ERR, 0, 1, S_ERR);
    cyc("error_sticky", '{rn: 1'b1, mreq: 1'b1, mrdy: 1'b1, default: '0}, ERR, 0, 1, S_ERR);
    cyc("error_reset", '{rn: 1'b0, default: '0}, RST, 0, 0, S_RUN);
    cyc("after_error_reset", IDLE, ADV, 0, 0, S_RUN);
    cyc("halt_priority", '{rn: 1'b1, halt: 1'b1, mreq: 1'b1, div: 1'b1, br: 1'b1, default: '0}, HLT, 0, 0, S_RUN);
    cyc("halted", IDLE, HLT, 0, 0, S_HLT);
    cyc("halted_ignores_div", '{rn: 1'b1, div: 1'b1, default: '0}, HLT, 0, 0, S_HLT);
    cyc("halt_reset", '{rn: 1'b0, default: '0}, RST, 0, 0, S_RUN);
    cyc("after_halt_reset", IDLE, ADV, 0, 0, S_RUN);
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the 16-bit, four-stage core. It decides each cycle whether the pipeline buffers (IF/ID, ID/EX, EX/M) advance, hold or flush. It covers load-use hazards, taken branches resolved in EX, multi-cycle divide in EX, wait-stated data memory, and halt. It drives the existing FLUSH_EX input of the EX/M buffer and the PC/IF/ID write enables.

## Interface
- DIV_CYCLES, 16: EX cycles a divide occupies (≥2).
- MEM_TIMEOUT, 255: MEM_WAIT cycles before a bus error.
- CNT_W, 8: counter width; must hold max(DIV_CYCLES-1, MEM_TIMEOUT).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_RegRD  in  4  destination register of the EX instruction.
- IFID_RegRS, IFID_RegRT  in  4 each  source registers of the ID instruction.
- IFID_UsesRS, IFID_UsesRT  in  1 each  the ID instruction reads that source.
- Branch_Taken  in  1  branch in EX is taken.
- Div_Start  in  1  EX holds a divide/remainder op.
- Mem_Req  in  1  the M-stage instruction reads or writes memory.
- Mem_Ready  in  1  memory completes the M-stage access this cycle.
- Halt  in  1  halt instruction reached M.
- PC_Write  out  1  PC may update.
- IFID_Write  out  1  IF/ID may load.
- IDEX_Hold  out  1  ID/EX keeps its contents.
- EXM_Hold  out  1  EX/M keeps its contents.
- FLUSH_IFID, FLUSH_IDEX, FLUSH_EX  out  1 each  load a bubble into that buffer.
- Div_Done  out  1  registered one-cycle pulse: divide result valid.
- Mem_Err  out  1  registered sticky bus-timeout flag.
- Ctrl_State  out  3  current FSM state, for debug.

## Operation
- States: RUN, DIV_WAIT, MEM_WAIT, ERROR, HALTED.
- Outputs are combinational from the state, the counter and the inputs. State, counter, Div_Done and Mem_Err are registered.
- Idle/advance values: PC_Write=1, IFID_Write=1, all holds and flushes 0.
- Priority in RUN, first match wins: Halt > (Mem_Req & !Mem_Ready) > Div_Start > Branch_Taken > load-use.
- Halt: go to HALTED. PC_Write=0, IFID_Write=0, FLUSH_IFID=1, FLUSH_IDEX=1.
- Memory not ready: go to MEM_WAIT and clear the counter. In that same cycle, all writes=0 and both holds=1.
- Div_Start: go to DIV_WAIT and load the counter with DIV_CYCLES-1. In that cycle, PC_Write=0, IFID_Write=0, IDEX_Hold=1, FLUSH_EX=1.
- Branch_Taken: FLUSH_IFID=1 and FLUSH_IDEX=1, PC_Write=1. Stay in RUN. A load-use hazard in the same cycle is ignored.
- Load-use: IDEX_MemRead & ((IFID_UsesRS & RS==RD) | (IFID_UsesRT & RT==RD)). Response: PC_Write=0, IFID_Write=0, FLUSH_IDEX=1. Stay in RUN. The bubble lasts exactly one cycle.
- DIV_WAIT: the counter decrements each cycle.
  - While the count is nonzero: PC_Write=0, IFID_Write=0, IDEX_Hold=1, FLUSH_EX=1.
  - When the count reaches 0: FLUSH_EX=0 and all enables=1, so the result passes. Div_Done pulses on the next edge and the state returns to RUN.
- MEM_WAIT: all writes=0, IDEX_Hold=1, EXM_Hold=1. The counter increments each cycle.
  - Mem_Ready=1: outputs return to advance values in the same cycle, and the state goes to RUN.
  - Counter reaches MEM_TIMEOUT without Mem_Ready: go to ERROR and set Mem_Err.
- ERROR and HALTED: all write enables=0 and FLUSH_IFID=1, FLUSH_IDEX=1. In ERROR, both holds also stay 1. These states are left only by reset.
- Deferred events: Div_Start or Branch_Taken arriving during MEM_WAIT is acted on after return to RUN, because ID/EX is held and the inputs persist. Branch_Taken together with Div_Start is illegal; Div_Start wins.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, counter=0, Div_Done=0, Mem_Err=0, Ctrl_State=RUN encoding.
- While rst_n=0, outputs are forced: PC_Write=0, IFID_Write=0, IDEX_Hold=0, EXM_Hold=0, FLUSH_IFID=FLUSH_IDEX=FLUSH_EX=1. Reset mid-divide or mid-wait abandons the operation.
- Hazard responses are zero-latency (same cycle as the inputs).
- A divide stalls the pipeline for exactly DIV_CYCLES-1 cycles. Div_Done is high in the cycle after the result passes EX.
- A memory access with k wait cycles stalls for k cycles. ERROR is entered after MEM_TIMEOUT+1 cycles in MEM_WAIT.

## Structure
- pipe_ctrl_pkg holds the state enumeration (RUN=0, DIV_WAIT=1, MEM_WAIT=2, ERROR=3, HALTED=4) and the default-output constants.
- One sub-module, ctrl_cycle_counter: CNT_W-bit, with load, increment, decrement and clear, plus a zero flag. DIV_WAIT and MEM_WAIT share it.

## Test plan
- Load to R3 in EX and an ID instruction using RS=R3 → one cycle of PC_Write=0 and FLUSH_IDEX=1, then the pipeline advances. With IFID_UsesRS=0, there is no stall.
- Branch_Taken with a simultaneous load-use match → FLUSH_IFID=FLUSH_IDEX=1, PC_Write=1, no stall.
- Div_Start with DIV_CYCLES=16 → 15 cycles of FLUSH_EX=1 and IDEX_Hold=1, then Div_Done pulses once, then back to RUN.
- Mem_Req with Mem_Ready low for 3 cycles → EXM_Hold=1 for exactly 3 cycles, then release. Div_Start raised during the wait starts DIV_WAIT only afterwards.
- Mem_Ready never asserted, MEM_TIMEOUT=4 → ERROR entered after 5 cycles, Mem_Err=1 and sticky. rst_n pulse → RUN, Mem_Err=0.
- rst_n asserted in the middle of DIV_WAIT → asynchronous return to RUN with the forced flush values. Halt → HALTED, which persists until reset.
